// File: rtl/fifo_rd_stage_pkg.sv
// Shared types and helpers for the FIFO read-side drain stage.
package fifo_rd_stage_pkg;

  // Skid buffer depth and occupancy type (0..2 fits in two bits).
  localparam int unsigned SKID_DEPTH = 2;

  typedef logic [1:0] buf_cnt_t;

  // True while the skid buffer can still accept a popped word.
  function automatic logic skid_has_room(input buf_cnt_t cnt);
    return (cnt < 2'd2);
  endfunction

endpackage

// File: rtl/fifo_rd_stage_skid_buf_2e.sv
// Two-entry registered skid buffer. Entry0 is the head presented downstream,
// entry1 is the skid slot. Occupancy and valid are registered.
module skid_buf_2e
  import fifo_rd_stage_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output buf_cnt_t     cnt_o
);

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  buf_cnt_t     cnt_q, cnt_d;
  logic         valid_q, valid_d;

  // Next-state: shift on pop, then write the pushed word at the new tail.
  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push_i) begin
          e0_d  = push_data_i;
          cnt_d = 2'd1;
        end else begin
          cnt_d = 2'd0;
        end
      end
      2'd1: begin
        if (push_i && pop_i) begin
          e0_d = push_data_i;
        end else if (push_i) begin
          e1_d  = push_data_i;
          cnt_d = 2'd2;
        end else if (pop_i) begin
          cnt_d = 2'd0;
        end else begin
          cnt_d = 2'd1;
        end
      end
      2'd2: begin
        if (push_i && pop_i) begin
          e0_d = e1_q;
          e1_d = push_data_i;
        end else if (pop_i) begin
          e0_d  = e1_q;
          cnt_d = 2'd1;
        end else begin
          cnt_d = 2'd2;
        end
      end
      default: begin
        cnt_d = 2'd0;
      end
    endcase
    valid_d = (cnt_d != 2'd0);
  end

  // Buffer state registers; reset empties the buffer and parks the head at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q    <= {W{1'b1}};
      e1_q    <= {W{1'b1}};
      cnt_q   <= 2'd0;
      valid_q <= 1'b0;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = e0_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/fifo_rd_stage.sv
// Read-side drain stage: pops a fall-through FIFO, filters the all-ones
// "no element" sentinel, paces pops and buffers words in a 2-entry skid buffer.
module fifo_rd_stage
  import fifo_rd_stage_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH     = 32,
  parameter int unsigned GAP_WIDTH      = 8,
  parameter int unsigned DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [GAP_WIDTH-1:0]      gap_cfg,
  input  logic                      data_avail,
  input  logic [FIFO_WIDTH-1:0]     r_data,
  output logic                      r_val,
  output logic                      out_val,
  output logic [FIFO_WIDTH-1:0]     out_data,
  input  logic                      out_rdy,
  output logic [1:0]                buf_cnt,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  // Upstream FIFO returns this word when it has no element.
  localparam logic [FIFO_WIDTH-1:0] ELEM_NONE = {FIFO_WIDTH{1'b1}};

  logic [GAP_WIDTH-1:0]      gap_q, gap_d;
  logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
  buf_cnt_t                  cnt_s;
  logic                      valid_s;
  logic                      is_sentinel_s;
  logic                      push_s;
  logic                      xfer_s;

  // Pop only from registered state, never from out_rdy; held low in reset.
  assign r_val = rst_n & enable & data_avail &
                 (gap_q == {GAP_WIDTH{1'b0}}) & skid_has_room(cnt_s);

  assign is_sentinel_s = (r_data == ELEM_NONE);
  assign push_s        = r_val & ~is_sentinel_s;
  assign xfer_s        = valid_s & out_rdy;

  // Gap reload on every pop (sentinel included) and saturating drop count.
  always_comb begin
    gap_d  = gap_q;
    drop_d = drop_q;
    if (r_val) begin
      gap_d = gap_cfg;
    end else if (gap_q != {GAP_WIDTH{1'b0}}) begin
      gap_d = gap_q - GAP_WIDTH'(1);
    end else begin
      gap_d = gap_q;
    end
    if (r_val && is_sentinel_s && (drop_q != {DROP_CNT_WIDTH{1'b1}})) begin
      drop_d = drop_q + DROP_CNT_WIDTH'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  // Pacing and drop counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q  <= {GAP_WIDTH{1'b0}};
      drop_q <= {DROP_CNT_WIDTH{1'b0}};
    end else begin
      gap_q  <= gap_d;
      drop_q <= drop_d;
    end
  end

  skid_buf_2e #(
    .W (FIFO_WIDTH)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push_s),
    .push_data_i (r_data),
    .pop_i       (xfer_s),
    .valid_o     (valid_s),
    .data_o      (out_data),
    .cnt_o       (cnt_s)
  );

  assign out_val  = valid_s;
  assign buf_cnt  = cnt_s;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_fifo_rd_stage.sv
// Directed bench for fifo_rd_stage with a small fall-through FIFO source model.
module tb_fifo_rd_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [7:0]  gap_cfg;
  logic        data_avail;
  logic [31:0] r_data;
  logic        r_val;
  logic        out_val;
  logic [31:0] out_data;
  logic        out_rdy;
  logic [1:0]  buf_cnt;
  logic [15:0] drop_cnt;

  logic [31:0] src_q[$];
  logic [31:0] got_q[$];
  logic [31:0] tmp;
  bit          sent_mode;
  bit          last_pop;
  int          total = 0;
  int          bad = 0;
  logic [11:0] pop_v;
  logic [11:0] val_v;

  always #5 clk = ~clk;

  fifo_rd_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .gap_cfg    (gap_cfg),
    .data_avail (data_avail),
    .r_data     (r_data),
    .r_val      (r_val),
    .out_val    (out_val),
    .out_data   (out_data),
    .out_rdy    (out_rdy),
    .buf_cnt    (buf_cnt),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present the head of the model FIFO (fall-through).
  task automatic drive_src();
    if (sent_mode) begin
      data_avail = 1'b1;
      r_data     = 32'hFFFF_FFFF;
    end else if (src_q.size() != 0) begin
      data_avail = 1'b1;
      r_data     = src_q[0];
    end else begin
      data_avail = 1'b0;
      r_data     = 32'h0;
    end
  endtask

  // One clock: note whether a pop is requested, clock it, retire popped word.
  task automatic tick();
    drive_src();
    #1;
    last_pop = r_val;
    @(posedge clk);
    #1;
    if (last_pop && !sent_mode) tmp = src_q.pop_front();
    drive_src();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    enable    = 1'b0;
    out_rdy   = 1'b0;
    gap_cfg   = 8'd0;
    sent_mode = 1'b0;
    src_q.delete();
    drive_src();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_out_val", {31'd0, out_val}, 32'd0);
    chk("rst_out_data", out_data, 32'hFFFF_FFFF);
    chk("rst_buf_cnt", {30'd0, buf_cnt}, 32'd0);
    chk("rst_drop_cnt", {16'd0, drop_cnt}, 32'd0);

    // Streaming: one word per cycle, buffer stays at 1
    enable = 1'b1; out_rdy = 1'b1;
    for (int i = 1; i <= 8; i++) src_q.push_back(i);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("stream_pop", {31'd0, last_pop}, 32'd1);
      chk("stream_data", out_data, i);
      chk("stream_cnt", {30'd0, buf_cnt}, 32'd1);
    end
    tick();
    chk("stream_end_pop", {31'd0, last_pop}, 32'd0);
    chk("stream_end_val", {31'd0, out_val}, 32'd0);

    // Backpressure: two pops fill the buffer, head held, then in-order drain
    do_reset();
    enable = 1'b1; out_rdy = 1'b0;
    for (int i = 0; i < 5; i++) src_q.push_back(32'h11 + i);
    tick(); tick();
    chk("bp_cnt", {30'd0, buf_cnt}, 32'd2);
    chk("bp_data", out_data, 32'h11);
    #1;
    chk("bp_rval", {31'd0, r_val}, 32'd0);
    tick(); tick();
    chk("bp_hold", out_data, 32'h11);
    chk("bp_left", src_q.size(), 32'd3);
    out_rdy = 1'b1;
    got_q.delete();
    repeat (10) begin
      if (out_val) got_q.push_back(out_data);
      tick();
    end
    chk("bp_n", got_q.size(), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("bp_order", got_q[i], 32'h11 + i);

    // Pacing: gap 3 gives pops every 4 cycles
    do_reset();
    enable = 1'b1; out_rdy = 1'b1; gap_cfg = 8'd3;
    for (int i = 0; i < 10; i++) src_q.push_back(32'h20 + i);
    for (int i = 0; i < 12; i++) begin
      tick();
      pop_v[i] = last_pop;
      val_v[i] = out_val;
    end
    chk("pace_pops", {20'd0, pop_v}, 32'h111);
    chk("pace_vals", {20'd0, val_v}, 32'h111);

    // Sentinel: popped, not forwarded, counted
    do_reset();
    enable = 1'b1; out_rdy = 1'b1;
    src_q.push_back(32'hFFFF_FFFF);
    tick();
    chk("sent_pop", {31'd0, last_pop}, 32'd1);
    chk("sent_drop", {16'd0, drop_cnt}, 32'd1);
    chk("sent_val", {31'd0, out_val}, 32'd0);
    chk("sent_cnt", {30'd0, buf_cnt}, 32'd0);
    out_rdy = 1'b0;
    src_q.push_back(32'h5); src_q.push_back(32'hFFFF_FFFF); src_q.push_back(32'h6);
    tick(); tick(); tick();
    chk("sent_mix_cnt", {30'd0, buf_cnt}, 32'd2);
    chk("sent_mix_data", out_data, 32'h5);
    chk("sent_mix_drop", {16'd0, drop_cnt}, 32'd2);

    // Drop counter saturation
    do_reset();
    enable = 1'b1; out_rdy = 1'b1; sent_mode = 1'b1;
    repeat (65534) tick();
    chk("sat_pre", {16'd0, drop_cnt}, 32'hFFFE);
    repeat (70000 - 65534) tick();
    chk("sat_drop", {16'd0, drop_cnt}, 32'hFFFF);
    chk("sat_cnt", {30'd0, buf_cnt}, 32'd0);
    sent_mode = 1'b0;

    // enable=0 blocks pops but buffered words drain
    do_reset();
    enable = 1'b1; out_rdy = 1'b0;
    src_q.push_back(32'h31); src_q.push_back(32'h32);
    tick(); tick();
    chk("ctl_fill", {30'd0, buf_cnt}, 32'd2);
    enable = 1'b0;
    src_q.push_back(32'h33); src_q.push_back(32'h34);
    drive_src();
    #1;
    chk("ctl_rval", {31'd0, r_val}, 32'd0);
    out_rdy = 1'b1;
    tick();
    chk("ctl_drain_data", out_data, 32'h32);
    chk("ctl_drain_cnt", {30'd0, buf_cnt}, 32'd1);
    tick();
    chk("ctl_empty", {30'd0, buf_cnt}, 32'd0);
    chk("ctl_nopop", {31'd0, last_pop}, 32'd0);
    chk("ctl_left", src_q.size(), 32'd2);

    // Asynchronous reset mid-stream
    enable = 1'b1; out_rdy = 1'b0;
    tick(); tick();
    chk("arst_fill", {30'd0, buf_cnt}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_val", {31'd0, out_val}, 32'd0);
    chk("arst_cnt", {30'd0, buf_cnt}, 32'd0);
    chk("arst_rval", {31'd0, r_val}, 32'd0);
    chk("arst_data", out_data, 32'hFFFF_FFFF);
    src_q.delete();
    drive_src();
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();
    chk("rel_nopop", {31'd0, last_pop}, 32'd0);
    chk("rel_noval", {31'd0, out_val}, 32'd0);
    src_q.push_back(32'h77);
    tick();
    chk("rel_pop", {31'd0, last_pop}, 32'd1);
    chk("rel_data", out_data, 32'h77);
    chk("rel_val", {31'd0, out_val}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
